// File: rtl/sub32_serial.sv
// Iterative 32-bit subtractor: a - b - bin, one 4-bit slice per clock, LSB slice first.
// Results and flags are updated only on the final-slice edge, so outputs never show partial work.
module sub32_serial (
  input  logic        m_clock,
  input  logic        p_reset,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        bin,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [31:0] diff,
  output logic        bout,
  output logic        ov,
  output logic        zero
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e      state_q;
  logic [2:0]  k_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [31:0] work_q;
  logic        borrow_q;

  logic [4:0]  sum;
  logic [31:0] work_d;

  // Operands shift right, so the active slice is always in bits [3:0]; the working
  // diff fills from the top so that slice 0 lands at the bottom after eight shifts.
  always_comb begin
    sum    = {1'b0, a_q[3:0]} + {1'b0, ~b_q[3:0]} + {4'b0, ~borrow_q};
    work_d = {sum[3:0], work_q[31:4]};
  end

  always_ff @(posedge m_clock) begin
    if (p_reset) begin
      state_q  <= StIdle;
      k_q      <= 3'd0;
      a_q      <= '0;
      b_q      <= '0;
      work_q   <= '0;
      borrow_q <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      diff     <= '0;
      bout     <= 1'b0;
      ov       <= 1'b0;
      zero     <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            a_q      <= a;
            b_q      <= b;
            borrow_q <= bin;
            work_q   <= '0;
            k_q      <= 3'd0;
            busy     <= 1'b1;
            state_q  <= StRun;
          end
        end
        StRun: begin
          a_q      <= {4'b0, a_q[31:4]};
          b_q      <= {4'b0, b_q[31:4]};
          borrow_q <= ~sum[4];
          work_q   <= work_d;
          k_q      <= k_q + 3'd1;
          if (k_q == 3'd7) begin
            // On the last slice a_q[3]/b_q[3] still hold the original sign bits.
            diff    <= work_d;
            bout    <= ~sum[4];
            ov      <= (a_q[3] != b_q[3]) && (sum[3] != a_q[3]);
            zero    <= (work_d == 32'd0);
            done    <= 1'b1;
            busy    <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_sub32_serial.sv
// Self-checking bench for sub32_serial: table-driven vectors plus hand-written
// sequences for ignored start, back-to-back operation and mid-operation reset.
module tb_sub32_serial;

  logic        m_clock;
  logic        p_reset;
  logic [31:0] a;
  logic [31:0] b;
  logic        bin;
  logic        start;
  logic        busy;
  logic        done;
  logic [31:0] diff;
  logic        bout;
  logic        ov;
  logic        zero;

  int checks = 0;
  int errors = 0;

  sub32_serial dut (
    .m_clock (m_clock),
    .p_reset (p_reset),
    .a       (a),
    .b       (b),
    .bin     (bin),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .diff    (diff),
    .bout    (bout),
    .ov      (ov),
    .zero    (zero)
  );

  initial m_clock = 1'b0;
  always #5 m_clock = ~m_clock;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        bin;
    logic [31:0] diff;
    logic        bout;
    logic        ov;
    logic        zero;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge m_clock);
    #1;
  endtask

  // Issues one operation, then waits (bounded) for done. Operands are scrambled
  // after acceptance so that any late sampling shows up in the result.
  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_v, input logic tbin,
                        output int lat, output int busy_cnt, output int changes);
    logic [31:0] prev;
    a = ta;
    b = tb_v;
    bin = tbin;
    start = 1'b1;
    prev = diff;
    tick();
    start = 1'b0;
    a = 32'hA5A5_5A5A;
    b = 32'h5A5A_A5A5;
    bin = ~tbin;
    lat = 0;
    busy_cnt = 0;
    changes = 0;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      if (done) begin
        lat = cyc;
        break;
      end
      if (busy) busy_cnt++;
      if (diff !== prev) changes++;
      tick();
    end
  endtask

  vec_t vecs[8];

  initial begin
    int lat;
    int bc;
    int chg;
    int extra_done;

    vecs[0] = '{32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0002, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{32'h0000_0010, 32'h0000_000F, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1};
    vecs[7] = '{32'h1234_5678, 32'h1111_1111, 1'b0, 32'h0123_4567, 1'b0, 1'b0, 1'b0};

    p_reset = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    bin = 1'b0;
    repeat (3) tick();
    check("reset busy", {31'b0, busy}, 32'd0);
    check("reset done", {31'b0, done}, 32'd0);
    check("reset diff", diff, 32'd0);
    check("reset flags", {29'b0, bout, ov, zero}, 32'd0);
    p_reset = 1'b0;
    tick();

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].bin, lat, bc, chg);
      check($sformatf("v%0d latency", i), lat, 32'd9);
      check($sformatf("v%0d busy cycles", i), bc, 32'd8);
      check($sformatf("v%0d diff stable", i), chg, 32'd0);
      check($sformatf("v%0d diff", i), diff, vecs[i].diff);
      check($sformatf("v%0d bout", i), {31'b0, bout}, {31'b0, vecs[i].bout});
      check($sformatf("v%0d ov", i), {31'b0, ov}, {31'b0, vecs[i].ov});
      check($sformatf("v%0d zero", i), {31'b0, zero}, {31'b0, vecs[i].zero});
      tick();
      check($sformatf("v%0d done pulse", i), {31'b0, done}, 32'd0);
    end

    // Ignored start in cycle 4, back-to-back start in cycle 9.
    a = 32'h1234_5678;
    b = 32'h1111_1111;
    bin = 1'b0;
    start = 1'b1;
    tick();
    extra_done = 0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      start = 1'b0;
      if (cyc == 4) begin
        check("ign busy c4", {31'b0, busy}, 32'd1);
        a = 32'hFFFF_FFFF;
        b = 32'h0000_0001;
        bin = 1'b1;
        start = 1'b1;
      end else if (cyc == 9) begin
        check("b2b done c9", {31'b0, done}, 32'd1);
        check("b2b busy c9", {31'b0, busy}, 32'd0);
        check("b2b diff c9", diff, 32'h0123_4567);
        a = 32'h0000_0001;
        b = 32'h0000_0002;
        bin = 1'b0;
        start = 1'b1;
      end else if (cyc == 18) begin
        check("b2b done c18", {31'b0, done}, 32'd1);
        check("b2b diff c18", diff, 32'hFFFF_FFFF);
        check("b2b bout c18", {31'b0, bout}, 32'd1);
      end else if (done) begin
        extra_done++;
      end
      tick();
    end
    check("b2b stray done", extra_done, 32'd0);

    // Reset asserted in cycle 5 of an operation.
    a = 32'h0000_0005;
    b = 32'h0000_0003;
    bin = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int cyc = 1; cyc < 5; cyc++) tick();
    p_reset = 1'b1;
    tick();
    p_reset = 1'b0;
    check("rst busy", {31'b0, busy}, 32'd0);
    check("rst diff", diff, 32'd0);
    check("rst flags", {28'b0, done, bout, ov, zero}, 32'd0);
    extra_done = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (done) extra_done++;
      tick();
    end
    check("rst no done", extra_done, 32'd0);

    // Reset wins over a simultaneous start.
    p_reset = 1'b1;
    start = 1'b1;
    tick();
    p_reset = 1'b0;
    start = 1'b0;
    check("rst vs start busy", {31'b0, busy}, 32'd0);
    tick();

    run_op(32'h0000_0005, 32'h0000_0003, 1'b0, lat, bc, chg);
    check("post-rst latency", lat, 32'd9);
    check("post-rst diff", diff, 32'h0000_0002);
    check("post-rst flags", {29'b0, bout, ov, zero}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
